// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared widths and FSM state encodings for the sequence detector.
package seq_detect_pkg;
  localparam int PAT_W = 8;
  localparam int CNT_W = 4;
  localparam int LEN_W = 3;
  typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, RUN = 2'b10, DONE = 2'b11} state_t;
endpackage

// File: rtl/seq_matcher.sv
// seq_matcher: history shift register, fill count and masked pattern compare.
module seq_matcher #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 3
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             overlap,
  output logic             hit
);
  localparam int FW = $clog2(PAT_W + 1);
  logic [PAT_W-1:0] history, next_hist, mask;
  logic [FW-1:0] fill, next_fill;
  // hit looks at the post-shift history so the bit being accepted counts
  always_comb begin
    next_hist = {history[PAT_W-2:0], bit_in};
    next_fill = (fill == FW'(PAT_W)) ? fill : fill + 1'b1;
    for (int i = 0; i < PAT_W; i++) mask[i] = (i <= int'(len));
    hit = shift && (((next_hist ^ pattern) & mask) == '0) && (int'(next_fill) > int'(len));
  end
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      history <= '0;
      fill    <= '0;
    end else if (clear) begin
      history <= '0;
      fill    <= '0;
    end else if (shift) begin
      history <= next_hist;
      fill    <= (hit && !overlap) ? '0 : next_fill;
    end
  end
endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: configurable serial pattern detector with run/abort control FSM.
module seq_detect_ctrl #(
  parameter int PAT_W = seq_detect_pkg::PAT_W,
  parameter int CNT_W = seq_detect_pkg::CNT_W
) (
  input  logic                           clock,
  input  logic                           rst,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [PAT_W-1:0]               cfg_pattern,
  input  logic [seq_detect_pkg::LEN_W-1:0] cfg_len,
  input  logic                           cfg_overlap,
  input  logic [7:0]                     cfg_nbits,
  input  logic                           data_valid,
  input  logic                           data_input,
  output logic                           data_ready,
  input  logic                           abort,
  output logic                           data_output,
  output logic [CNT_W-1:0]               det_count,
  output logic                           busy,
  output logic                           done,
  output logic [1:0]                     state
);
  import seq_detect_pkg::*;
  state_t st;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic overlap, shift, hit;
  logic [7:0] nbits, bcnt;
  assign state      = st;
  assign cfg_ready  = (st == IDLE);
  assign data_ready = (st == RUN);
  assign busy       = (st != IDLE);
  assign shift      = (st == RUN) && data_valid && !abort;
  seq_matcher #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_matcher (
    .clock(clock), .rst(rst), .clear(st == LOAD), .shift(shift), .bit_in(data_input),
    .pattern(pattern), .len(len), .overlap(overlap), .hit(hit)
  );
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      st          <= IDLE;
      pattern     <= '0;
      len         <= '0;
      overlap     <= 1'b0;
      nbits       <= '0;
      bcnt        <= '0;
      det_count   <= '0;
      data_output <= 1'b0;
      done        <= 1'b0;
    end else begin
      data_output <= 1'b0;
      done        <= 1'b0;
      case (st)
        IDLE: if (cfg_valid) begin
          pattern <= cfg_pattern;
          len     <= cfg_len;
          overlap <= cfg_overlap;
          nbits   <= cfg_nbits;
          st      <= LOAD;
        end
        LOAD: begin
          bcnt      <= '0;
          det_count <= '0;
          st        <= (nbits == '0) ? DONE : RUN;
          done      <= (nbits == '0);
        end
        RUN: if (abort) st <= IDLE;
        else if (data_valid) begin
          bcnt        <= bcnt + 8'd1;
          data_output <= hit;
          if (hit) det_count <= (det_count == '1) ? det_count : det_count + 1'b1;
          if (bcnt + 8'd1 == nbits) begin
            st   <= DONE;
            done <= 1'b1;
          end
        end
        DONE: st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end
endmodule
